vdc_sched: RTL and testbench

Period scheduler and soft-start controller for a bank of NCH variable-duty-cycle (VDC) PWM channels. It generates the shared one-cycle period trigger, stages each channel's enable on successive period boundaries to spread inrush load, and double-buffers per-channel high-count (NH) updates so all channels change duty cycle only at a period boundary. It sits between the servo loops, which write NH at arbitrary times, and the VDC output stages, which consume `vdc_trig`, `on[k]` and `NH[k]`.

---
 rtl/vdc_sched.sv | 165 ++++++++++++++++
 tb/tb_vdc_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vdc_sched.sv
// vdc_sched: shared period trigger, staggered soft-start/drain of NCH VDC channels,
// and double-buffered NH updates that only take effect on a period boundary.
module vdc_sched #(
   parameter int unsigned  NCH    = 4,
   parameter int           NT_MIN = 2,
   localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic signed [31:0]    NT,
   input  logic                  nh_wr,
   input  logic [CHW-1:0]        nh_ch,
   input  logic signed [31:0]    nh_in,
   output logic                  vdc_trig,
   output logic [NCH-1:0]        on,
   output logic [NCH*32-1:0]     NH,
   output logic [NCH-1:0]        sat,
   output logic [1:0]            state
);

   localparam int unsigned DW = 32;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_STAGGER = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   localparam logic signed [DW-1:0] NT_MIN_S = DW'(NT_MIN);

   logic [1:0]                state_q, state_d;
   logic [DW-1:0]             pcnt_q, pcnt_d;
   logic signed [DW-1:0]      nt_l_q, nt_l_d;
   logic                      trig_q, trig_d;
   logic [NCH-1:0]            on_q, on_d;
   logic [NCH-1:0][DW-1:0]    nh_q, nh_d;
   logic [NCH-1:0][DW-1:0]    shadow_q, shadow_d;
   logic [NCH-1:0]            sat_q, sat_d;
   logic [NCH-1:0]            pend_q, pend_d;

   logic signed [DW-1:0]      nt_new;
   logic [DW-1:0]             per_len;
   logic                      boundary;
   logic [NCH-1:0]            on_up;
   logic [NCH-1:0]            on_dn;

   // Period length for the period starting now, and the contiguous enable masks.
   assign nt_new   = (NT < NT_MIN_S) ? NT_MIN_S : NT;
   assign boundary = (state_q != S_IDLE) && (pcnt_q == '0);
   assign per_len  = (pcnt_q == '0) ? nt_new : nt_l_q;
   assign on_up    = NCH'({on_q, 1'b1});
   assign on_dn    = on_q >> 1;

   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      nt_l_d   = nt_l_q;
      trig_d   = boundary;
      on_d     = on_q;
      nh_d     = nh_q;
      sat_d    = sat_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;

      if (pcnt_q == '0) nt_l_d = nt_new;

      // Apply uses the pre-write shadow; a same-cycle write re-arms pending below.
      if (boundary) begin
         for (int k = 0; k < int'(NCH); k++) begin
            if (pend_q[k]) begin
               pend_d[k] = 1'b0;
               if ($signed(shadow_q[k]) < 32'sd0) begin
                  nh_d[k]  = '0;
                  sat_d[k] = 1'b1;
               end else if ($signed(shadow_q[k]) > nt_new) begin
                  nh_d[k]  = nt_new;
                  sat_d[k] = 1'b1;
               end else begin
                  nh_d[k]  = shadow_q[k];
                  sat_d[k] = 1'b0;
               end
            end
         end
      end

      if (nh_wr) begin
         for (int k = 0; k < int'(NCH); k++) begin
            if (nh_ch == CHW'(k)) begin
               shadow_d[k] = nh_in;
               pend_d[k]   = 1'b1;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_STAGGER;
         end
         S_STAGGER: begin
            if (!en) begin
               state_d = S_DRAIN;
            end else if (&on_q) begin
               state_d = S_RUN;
            end else if (boundary) begin
               on_d = on_up;
               if (&on_up) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!en) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (en) begin
               state_d = S_STAGGER;
            end else if (on_q == '0) begin
               state_d = S_IDLE;
            end else if (boundary) begin
               on_d = on_dn;
               if (on_dn == '0) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Counter sits at 0 in IDLE so the first cycle after leaving IDLE is a boundary.
      if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
         pcnt_d = '0;
      end else if (pcnt_q >= (per_len - DW'(1))) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pcnt_q   <= '0;
         nt_l_q   <= NT_MIN_S;
         trig_q   <= 1'b0;
         on_q     <= '0;
         nh_q     <= '0;
         shadow_q <= '0;
         sat_q    <= '0;
         pend_q   <= '0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         nt_l_q   <= nt_l_d;
         trig_q   <= trig_d;
         on_q     <= on_d;
         nh_q     <= nh_d;
         shadow_q <= shadow_d;
         sat_q    <= sat_d;
         pend_q   <= pend_d;
      end
   end

   assign vdc_trig = trig_q;
   assign on       = on_q;
   assign NH       = nh_q;
   assign sat      = sat_q;
   assign state    = state_q;

endmodule

// File: tb/tb_vdc_sched.sv
// tb_vdc_sched: directed stimulus with a scoreboard of expected vdc_trig responses
// popped by an independent monitor on every trigger pulse.
module tb_vdc_sched;

   localparam logic [1:0] SI = 2'd0;
   localparam logic [1:0] SS = 2'd1;
   localparam logic [1:0] SR = 2'd2;
   localparam logic [1:0] SD = 2'd3;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic signed [31:0]  NT;
   logic                nh_wr;
   logic [1:0]          nh_ch;
   logic signed [31:0]  nh_in;
   logic                vdc_trig;
   logic [3:0]          on;
   logic [127:0]        NH;
   logic [3:0]          sat;
   logic [1:0]          state;

   typedef struct {
      int           rel;
      logic [3:0]   on;
      logic [1:0]   st;
      logic [127:0] nh;
      logic [3:0]   sat;
   } exp_t;

   exp_t         sb[$];
   int           cyc = 0;
   int           t0 = 0;
   int           n_chk = 0;
   int           n_fail = 0;
   logic         rst_prev;
   logic [3:0]   prev_on;
   logic [127:0] prev_nh;

   vdc_sched #(.NCH(4), .NT_MIN(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .NT       (NT),
      .nh_wr    (nh_wr),
      .nh_ch    (nh_ch),
      .nh_in    (nh_in),
      .vdc_trig (vdc_trig),
      .on       (on),
      .NH       (NH),
      .sat      (sat),
      .state    (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_prev <= rst;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
      end
   endtask

   task automatic push(input int rel, input logic [3:0] o, input logic [1:0] st,
                       input int n0, input int n1, input int n2, input int n3,
                       input logic [3:0] s);
      exp_t e;
      e.rel = rel;
      e.on  = o;
      e.st  = st;
      e.nh  = {32'(n3), 32'(n2), 32'(n1), 32'(n0)};
      e.sat = s;
      sb.push_back(e);
   endtask

   task automatic at(input int rel);
      while (cyc - t0 < rel) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] ch, input logic signed [31:0] d);
      nh_wr = 1'b1;
      nh_ch = ch;
      nh_in = d;
      @(posedge clk);
      #1;
      nh_wr = 1'b0;
   endtask

   // Monitor: each trigger pops one expectation; between triggers on/NH must hold.
   always @(negedge clk) begin : mon
      exp_t e;
      if (vdc_trig === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_trig", 128'(cyc - t0), 128'(-1));
         end else begin
            e = sb.pop_front();
            chk("trig_cycle", 128'(cyc - t0), 128'(e.rel));
            chk("trig_on",    128'(on),       128'(e.on));
            chk("trig_state", 128'(state),    128'(e.st));
            chk("trig_nh",    NH,             e.nh);
            chk("trig_sat",   128'(sat),      128'(e.sat));
         end
      end else if (rst_prev === 1'b0) begin
         chk("hold_on", 128'(on), 128'(prev_on));
         chk("hold_nh", NH, prev_nh);
      end
      prev_on = on;
      prev_nh = NH;
   end

   initial begin : timeout
      #100000;
      $display("FAIL timeout: got running expected finished (cycle %0d)", cyc - t0);
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stim
      rst   = 1'b1;
      en    = 1'b0;
      NT    = 32'sd10;
      nh_wr = 1'b0;
      nh_ch = 2'd0;
      nh_in = 32'sd0;

      // Soft start, double-buffered writes, clamp and boundary-cycle write
      push(  2, 4'b0001, SS, 0,  0, 0, 0, 4'b0000);
      push( 12, 4'b0011, SS, 0,  0, 0, 0, 4'b0000);
      push( 22, 4'b0111, SS, 0,  0, 0, 0, 4'b0000);
      push( 32, 4'b1111, SR, 0,  0, 0, 0, 4'b0000);
      push( 42, 4'b1111, SR, 0,  0, 7, 0, 4'b0000);
      push( 52, 4'b1111, SR, 0,  0, 3, 0, 4'b0000);
      push( 62, 4'b1111, SR, 0, 10, 3, 0, 4'b0010);
      push( 72, 4'b1111, SR, 0,  0, 3, 0, 4'b0010);
      push( 82, 4'b1111, SR, 0,  5, 3, 0, 4'b0000);
      push( 92, 4'b1111, SR, 4,  5, 3, 0, 4'b0000);
      // NT 10 -> 6, then 0 (forced to 2), then back to 10
      push( 98, 4'b1111, SR, 4,  5, 3, 0, 4'b0000);
      push(104, 4'b1111, SR, 4,  5, 3, 0, 4'b0000);
      for (int r = 110; r <= 122; r += 2) push(r, 4'b1111, SR, 4, 5, 3, 0, 4'b0000);
      // Drain and re-enable
      push(132, 4'b0111, SD, 4,  5, 3, 0, 4'b0000);
      push(142, 4'b0011, SD, 4,  5, 3, 0, 4'b0000);
      push(152, 4'b0111, SS, 4,  5, 3, 0, 4'b0000);
      // Restart after reset: pending ch3 write must not surface
      push(158, 4'b0001, SS, 0,  0, 0, 0, 4'b0000);
      push(168, 4'b0011, SS, 0,  0, 0, 0, 4'b0000);
      push(178, 4'b0001, SD, 0,  0, 0, 0, 4'b0000);
      push(188, 4'b0000, SI, 0,  0, 0, 0, 4'b0000);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 128'(state),    128'(SI));
      chk("rst_trig",  128'(vdc_trig), 128'(0));
      chk("rst_on",    128'(on),       128'(0));
      chk("rst_nh",    NH,             128'(0));
      chk("rst_sat",   128'(sat),      128'(0));

      rst = 1'b0;
      t0  = cyc;
      en  = 1'b1;
      at(1);
      chk("stagger_entry", 128'(state), 128'(SS));

      at(35);  wr(2'd2, 32'sd7);
      at(45);  wr(2'd2, 32'sd7);
      at(48);  wr(2'd2, 32'sd3);
      at(55);  wr(2'd1, 32'sd25);
      at(65);  wr(2'd1, -32'sd4);
      at(75);  wr(2'd1, 32'sd5);
      at(81);  wr(2'd0, 32'sd4);
      at(85);  NT = 32'sd6;
      at(105); NT = 32'sd0;
      at(120); NT = 32'sd10;
      at(125); en = 1'b0;
      at(145); en = 1'b1;
      at(153); wr(2'd3, 32'sd9);
      at(155); rst = 1'b1;
      at(156);
      rst = 1'b0;
      chk("mid_rst_state", 128'(state),    128'(SI));
      chk("mid_rst_trig",  128'(vdc_trig), 128'(0));
      chk("mid_rst_on",    128'(on),       128'(0));
      chk("mid_rst_nh",    NH,             128'(0));
      chk("mid_rst_sat",   128'(sat),      128'(0));
      at(157);
      chk("restart_state", 128'(state), 128'(SS));
      at(170); en = 1'b0;
      at(200);
      chk("sb_empty", 128'(sb.size()), 128'(0));
      chk("final_state", 128'(state), 128'(SI));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
